// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared types and sizing helpers for the counter bank.
//   dir_e     : count direction carried on up_down (DOWN=0, UP=1)
//   mode_e    : event behaviour carried on sat_mode (WRAP=0, SAT=1)
//   sum_width : width that holds count+step without loss
package counter_bank_pkg;

  typedef enum logic {DOWN = 1'b0, UP  = 1'b1} dir_e;
  typedef enum logic {WRAP = 1'b0, SAT = 1'b1} mode_e;

  // One bit wider than the wider operand, so count+step and count+limit+1
  // never truncate before the range check.
  function automatic int sum_width(input int w, input int sw);
    return ((w > sw) ? w : sw) + 1;
  endfunction

endpackage

// File: rtl/counter_bank_ch.sv
// counter_bank_ch: one up/down modulus counter channel.
//   clk, rst        : clock, synchronous active-high reset
//   ce, up_down     : count enable, direction (1 = up)
//   load_n          : active-low load of min(data_load, limit)
//   limit, step     : terminal value (range 0..limit), increment (0 = hold)
//   sat_mode        : saturate on events (only when COUNTER_BANK_SAT_EN)
//   clr_flags       : clears sticky ovf/unf (a same-cycle event wins)
//   count           : registered count
//   max_count, zero : combinational compares of count
//   tc, ovf, unf    : terminal-count pulse, sticky overflow/underflow
// Macro COUNTER_BANK_SAT_EN compiles in saturate mode.
module counter_bank_ch
  import counter_bank_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              up_down,
  input  logic              load_n,
  input  logic [WIDTH-1:0]  data_load,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              max_count,
  output logic              zero,
  output logic              tc,
  output logic              ovf,
  output logic              unf
);

  localparam int SW = sum_width(WIDTH, STEP_W);

  logic [SW-1:0]    cnt_x, lim_x, mod_x, step_x, step_r, sum_up;
  logic [WIDTH-1:0] wrap_up, wrap_dn, diff_dn, cnt_nxt;
  logic             ovf_evt, unf_evt, above, sat;
  dir_e             dir;

  assign dir    = dir_e'(up_down);
  assign cnt_x  = SW'(count);
  assign lim_x  = SW'(limit);
  assign step_x = SW'(step);
  assign mod_x  = lim_x + 1'b1;
  assign above  = cnt_x > lim_x;

  // Modulo reduction keeps the wrapped result inside 0..limit even when
  // step exceeds limit+1.
  assign sum_up  = cnt_x + step_x;
  assign step_r  = step_x % mod_x;
  assign wrap_up = WIDTH'(sum_up % mod_x);
  assign wrap_dn = WIDTH'((cnt_x + mod_x - step_r) % mod_x);
  assign diff_dn = WIDTH'(cnt_x - step_x);

`ifdef COUNTER_BANK_SAT_EN
  assign sat = (mode_e'(sat_mode) == SAT);
`else
  logic unused_sat;
  assign unused_sat = sat_mode;
  assign sat        = 1'b0;
`endif

  always_comb begin
    cnt_nxt = count;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (!load_n) begin
      cnt_nxt = (data_load > limit) ? limit : data_load;
    end else if (ce) begin
      if (above) begin
        // limit was lowered under the count: pull back, not an event
        cnt_nxt = limit;
      end else if (dir == UP) begin
        if (sum_up > lim_x) begin
          ovf_evt = 1'b1;
          cnt_nxt = sat ? limit : wrap_up;
        end else begin
          cnt_nxt = WIDTH'(sum_up);
        end
      end else begin
        if (cnt_x < step_x) begin
          unf_evt = 1'b1;
          cnt_nxt = sat ? '0 : wrap_dn;
        end else begin
          cnt_nxt = diff_dn;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= cnt_nxt;
      tc    <= ovf_evt | unf_evt;
      ovf   <= (ovf & ~clr_flags) | ovf_evt;
      unf   <= (unf & ~clr_flags) | unf_evt;
    end
  end

  assign max_count = (count == limit);
  assign zero      = (count == '0);

endmodule

// File: rtl/counter_bank.sv
// counter_bank: NCH independent up/down modulus counters on one clock.
//   clk, rst   : clock, synchronous active-high reset
//   ce, up_down, load_n, sat_mode : per-channel controls [NCH]
//   data_load, limit : per-channel values, channel i at [i*WIDTH +: WIDTH]
//   step       : per-channel increment, channel i at [i*STEP_W +: STEP_W]
//   clr_flags  : clears every sticky ovf/unf
//   count_out  : registered counts, same slicing as data_load
//   max_count, zero : combinational per-channel compares
//   tc, ovf, unf    : per-channel terminal pulse and sticky flags
// Macro COUNTER_BANK_SAT_EN enables per-channel saturate mode.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NCH    = 4,
  parameter int STEP_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        ce,
  input  logic [NCH-1:0]        up_down,
  input  logic [NCH-1:0]        load_n,
  input  logic [NCH*WIDTH-1:0]  data_load,
  input  logic [NCH*WIDTH-1:0]  limit,
  input  logic [NCH*STEP_W-1:0] step,
  input  logic [NCH-1:0]        sat_mode,
  input  logic                  clr_flags,
  output logic [NCH*WIDTH-1:0]  count_out,
  output logic [NCH-1:0]        max_count,
  output logic [NCH-1:0]        zero,
  output logic [NCH-1:0]        tc,
  output logic [NCH-1:0]        ovf,
  output logic [NCH-1:0]        unf
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    counter_bank_ch #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce[i]),
      .up_down   (up_down[i]),
      .load_n    (load_n[i]),
      .data_load (data_load[i*WIDTH +: WIDTH]),
      .limit     (limit[i*WIDTH +: WIDTH]),
      .step      (step[i*STEP_W +: STEP_W]),
      .sat_mode  (sat_mode[i]),
      .clr_flags (clr_flags),
      .count     (count_out[i*WIDTH +: WIDTH]),
      .max_count (max_count[i]),
      .zero      (zero[i]),
      .tc        (tc[i]),
      .ovf       (ovf[i]),
      .unf       (unf[i])
    );
  end

endmodule
